traffic_seq_ctrl: RTL and testbench

Traffic-light sequencing FSM that drives the interval select of the time-parameter block and consumes its programmed duration. It runs the main/side green and yellow phases plus an optional pedestrian walk phase. Each phase lasts a number of one-second ticks loaded from the returned time value. Vehicle sensor and walk request are synchronised and latched internally.

---
 rtl/traffic_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_traffic_seq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_seq_ctrl.sv
// Traffic-light sequencer: steps main/side green and yellow phases plus an optional
// walk phase, each timed by a duration fetched from the time-parameter block.
module traffic_seq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_TIME    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_sec_en,
    input  logic       sensor,
    input  logic       walk_req,
    input  logic       prog_sync,
    input  logic [3:0] time_val,
    output logic [1:0] intervel,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       busy_load
);

    typedef enum logic [2:0] {
        S_MG1 = 3'd0,
        S_MG2 = 3'd1,
        S_MY  = 3'd2,
        S_SG  = 3'd3,
        S_SY  = 3'd4,
        S_WK  = 3'd5
    } state_t;

    localparam logic [1:0] SEL_TBASE = 2'b00;
    localparam logic [1:0] SEL_TEXT  = 2'b01;
    localparam logic [1:0] SEL_TYEL  = 2'b10;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [3:0] MIN_T = 4'(MIN_TIME);

    // Registered state
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sensor_sync_q, walk_sync_q;
    logic                   walk_latch_q, walk_latch_d;
    logic                   busy_q, busy_d;
    logic                   settle_q, settle_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [1:0]             sel_q, sel_d;
    logic [2:0]             main_q, main_d;
    logic [2:0]             side_q, side_d;
    logic                   walk_q, walk_d;

    logic       sensor_s;
    logic       walk_s;
    logic       expire;
    logic       enter;
    logic [3:0] load_val;

    assign sensor_s = sensor_sync_q[SYNC_STAGES-1];
    assign walk_s   = walk_sync_q[SYNC_STAGES-1];

    // Expiry is the tick that finds the counter at its last second.
    assign expire   = !busy_q && one_sec_en && (cnt_q == 4'd1);
    assign load_val = (time_val < MIN_T) ? MIN_T : time_val;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d      = state_q;
        enter        = 1'b0;
        sel_d        = sel_q;
        main_d       = main_q;
        side_d       = side_q;
        walk_d       = walk_q;
        busy_d       = busy_q;
        settle_d     = settle_q;
        cnt_d        = cnt_q;
        walk_latch_d = walk_latch_q | walk_s;

        if (prog_sync) begin
            state_d = S_MG1;
            enter   = 1'b1;
        end else if (expire) begin
            enter = 1'b1;
            case (state_q)
                S_MG1:   state_d = S_MG2;
                S_MG2:   state_d = S_MY;
                S_MY:    state_d = sensor_s ? S_SG : (walk_latch_q ? S_WK : S_MG1);
                S_SG:    state_d = S_SY;
                S_SY:    state_d = walk_latch_q ? S_WK : S_MG1;
                S_WK:    state_d = S_MG1;
                default: state_d = S_MG1;
            endcase
        end

        if (enter) begin
            busy_d   = 1'b1;
            settle_d = 1'b0;
            walk_d   = 1'b0;
            case (state_d)
                S_MG1: begin
                    sel_d  = SEL_TBASE;
                    main_d = LAMP_GRN;
                    side_d = LAMP_RED;
                end
                S_MG2: begin
                    sel_d  = sensor_s ? SEL_TEXT : SEL_TBASE;
                    main_d = LAMP_GRN;
                    side_d = LAMP_RED;
                end
                S_MY: begin
                    sel_d  = SEL_TYEL;
                    main_d = LAMP_YEL;
                    side_d = LAMP_RED;
                end
                S_SG: begin
                    sel_d  = SEL_TEXT;
                    main_d = LAMP_RED;
                    side_d = LAMP_GRN;
                end
                S_SY: begin
                    sel_d  = SEL_TYEL;
                    main_d = LAMP_RED;
                    side_d = LAMP_YEL;
                end
                S_WK: begin
                    sel_d        = SEL_TEXT;
                    main_d       = LAMP_RED;
                    side_d       = LAMP_RED;
                    walk_d       = 1'b1;
                    walk_latch_d = 1'b0;
                end
                default: begin
                    sel_d  = SEL_TBASE;
                    main_d = LAMP_RED;
                    side_d = LAMP_RED;
                end
            endcase
        end else if (busy_q) begin
            // Second settle cycle: the selected duration is now on time_val.
            if (settle_q) begin
                cnt_d  = load_val;
                busy_d = 1'b0;
            end else begin
                settle_d = 1'b1;
            end
        end else if (one_sec_en && (cnt_q > 4'd1)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_MG1;
            sensor_sync_q <= '0;
            walk_sync_q   <= '0;
            walk_latch_q  <= 1'b0;
            busy_q        <= 1'b1;
            settle_q      <= 1'b0;
            cnt_q         <= 4'd0;
            sel_q         <= SEL_TBASE;
            main_q        <= LAMP_GRN;
            side_q        <= LAMP_RED;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sensor_sync_q <= {sensor_sync_q[SYNC_STAGES-2:0], sensor};
            walk_sync_q   <= {walk_sync_q[SYNC_STAGES-2:0], walk_req};
            walk_latch_q  <= walk_latch_d;
            busy_q        <= busy_d;
            settle_q      <= settle_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            main_q        <= main_d;
            side_q        <= side_d;
            walk_q        <= walk_d;
        end
    end

    assign intervel   = sel_q;
    assign main_light = main_q;
    assign side_light = side_q;
    assign walk       = walk_q;
    assign busy_load  = busy_q;

endmodule

// File: tb/tb_traffic_seq_ctrl.sv
// Directed bench for traffic_seq_ctrl; a small behavioural time-parameter block
// returns tbase/text/tyel with one cycle of registration.
module tb_traffic_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_sec_en;
    logic       sensor;
    logic       walk_req;
    logic       prog_sync;
    logic [3:0] time_val;
    logic [1:0] intervel;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       busy_load;

    logic [3:0] tbase, text, tyel;
    int         checks = 0;
    int         errors = 0;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    traffic_seq_ctrl #(.SYNC_STAGES(2), .MIN_TIME(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .one_sec_en (one_sec_en),
        .sensor     (sensor),
        .walk_req   (walk_req),
        .prog_sync  (prog_sync),
        .time_val   (time_val),
        .intervel   (intervel),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .busy_load  (busy_load)
    );

    always #5 clk = ~clk;

    // Time-parameter block stand-in: registered lookup of the selected interval.
    always @(posedge clk) begin
        case (intervel)
            2'b00:   time_val <= tbase;
            2'b01:   time_val <= text;
            2'b10:   time_val <= tyel;
            default: time_val <= 4'd0;
        endcase
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One tick every 10 clocks; returns at the negedge after the tick was sampled.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (9) @(negedge clk);
            one_sec_en = 1'b1;
            @(negedge clk);
            one_sec_en = 1'b0;
        end
    endtask

    // Lamp safety monitor on every cycle out of reset.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("safety_lamps", {7'd0, (main_light !== RED) && (side_light !== RED)}, 8'd0);
            check("safety_walk", {7'd0, (walk === 1'b1) && ((main_light !== RED) || (side_light !== RED))}, 8'd0);
        end
    end

    initial begin
        reset      = 1'b1;
        one_sec_en = 1'b0;
        sensor     = 1'b0;
        walk_req   = 1'b0;
        prog_sync  = 1'b0;
        tbase      = 4'd6;
        text       = 4'd3;
        tyel       = 4'd2;

        // 1: reset values, then MG1 -> MG2 -> MY -> MG1
        repeat (2) @(negedge clk);
        check("rst_main", 8'(main_light), 8'(GRN));
        check("rst_side", 8'(side_light), 8'(RED));
        check("rst_sel", 8'(intervel), 8'h00);
        check("rst_walk", 8'(walk), 8'h00);
        check("rst_busy", 8'(busy_load), 8'h01);
        reset = 1'b0;
        @(negedge clk);
        check("t1_settle", 8'(busy_load), 8'h01);
        @(negedge clk);
        check("t1_loaded", 8'(busy_load), 8'h00);
        ticks(5);
        check("t1_mg1_hold", {main_light, 1'b0, busy_load}, {GRN, 1'b0, 1'b0});
        ticks(1);
        check("t1_mg2_entry", {main_light, intervel, busy_load}, {GRN, 2'b00, 1'b1});
        ticks(5);
        check("t1_mg2_hold", 8'(main_light), 8'(GRN));
        ticks(1);
        check("t1_my_entry", {main_light, intervel}, {YEL, 2'b10});
        check("t1_my_side", 8'(side_light), 8'(RED));
        ticks(1);
        check("t1_my_hold", 8'(main_light), 8'(YEL));
        ticks(1);
        check("t1_mg1_again", {main_light, intervel, busy_load}, {GRN, 2'b00, 1'b1});
        check("t1_side", 8'(side_light), 8'(RED));

        // 2: sensor set -> MG2 on text, then SG and SY
        sensor = 1'b1;
        ticks(6);
        check("t2_mg2_text", {main_light, intervel}, {GRN, 2'b01});
        ticks(2);
        check("t2_mg2_hold", 8'(main_light), 8'(GRN));
        ticks(1);
        check("t2_my_entry", 8'(main_light), 8'(YEL));
        ticks(2);
        check("t2_sg_entry", {main_light, side_light, intervel}, {RED, GRN, 2'b01});
        ticks(2);
        check("t2_sg_hold", 8'(side_light), 8'(GRN));
        ticks(1);
        check("t2_sy_entry", {main_light, side_light, intervel}, {RED, YEL, 2'b10});
        ticks(1);
        check("t2_sy_hold", 8'(side_light), 8'(YEL));
        ticks(1);
        check("t2_mg1", {main_light, side_light}, {GRN, RED});
        sensor = 1'b0;

        // 3: walk request -> WK after MY, latch then cleared
        @(negedge clk);
        walk_req = 1'b1;
        @(negedge clk);
        walk_req = 1'b0;
        ticks(6 + 6 + 2);
        check("t3_wk_entry", {walk, main_light, side_light}, {1'b1, RED, RED});
        check("t3_wk_sel", 8'(intervel), 8'h01);
        ticks(2);
        check("t3_wk_hold", 8'(walk), 8'h01);
        ticks(1);
        check("t3_wk_exit", {walk, main_light, intervel}, {1'b0, GRN, 2'b00});
        ticks(6 + 6 + 2);
        check("t3_skip_wk", {walk, main_light, busy_load}, {1'b0, GRN, 1'b1});

        // 4: tyel returns 0 -> MY lasts one tick
        tyel = 4'd0;
        ticks(6 + 6);
        check("t4_my_entry", 8'(main_light), 8'(YEL));
        ticks(1);
        check("t4_my_min", {main_light, busy_load}, {GRN, 1'b1});
        tyel = 4'd2;

        // 5: tick during T+1 is ignored
        ticks(6);
        check("t5_mg2_entry", 8'(busy_load), 8'h01);
        one_sec_en = 1'b1;
        @(negedge clk);
        one_sec_en = 1'b0;
        check("t5_ignored", {main_light, busy_load}, {GRN, 1'b1});
        ticks(5);
        check("t5_mg2_full", {main_light, busy_load}, {GRN, 1'b0});
        ticks(1);
        check("t5_my_entry", 8'(main_light), 8'(YEL));

        // 6a: asynchronous reset in the middle of SG
        sensor = 1'b1;
        ticks(2);
        check("t6_sg", {main_light, side_light}, {RED, GRN});
        ticks(1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_main", 8'(main_light), 8'(GRN));
        check("t6_rst_side", 8'(side_light), 8'(RED));
        check("t6_rst_sel", {intervel, walk, busy_load}, {2'b00, 1'b0, 1'b1});
        sensor = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // 6b: prog_sync beats a simultaneous MG2 expiry, then prog_sync mid-MY
        ticks(6);
        check("t6_mg2_entry", {main_light, busy_load}, {GRN, 1'b1});
        ticks(5);
        repeat (9) @(negedge clk);
        one_sec_en = 1'b1;
        prog_sync  = 1'b1;
        @(negedge clk);
        one_sec_en = 1'b0;
        prog_sync  = 1'b0;
        check("t6_prog_wins", {main_light, intervel, busy_load}, {GRN, 2'b00, 1'b1});
        ticks(6 + 6);
        check("t6_my_entry", 8'(main_light), 8'(YEL));
        ticks(1);
        repeat (3) @(negedge clk);
        prog_sync = 1'b1;
        @(negedge clk);
        prog_sync = 1'b0;
        check("t6_prog_my", {main_light, intervel, busy_load}, {GRN, 2'b00, 1'b1});
        check("t6_prog_side", 8'(side_light), 8'(RED));
        @(negedge clk);
        check("t6_prog_busy2", 8'(busy_load), 8'h01);
        @(negedge clk);
        check("t6_prog_load", 8'(busy_load), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
